saxis_frame_checker: RTL

Downstream AXI4-Stream slave that terminates the synthetic video stream produced by the test-pattern master (`maxis_v1_0_M00_AXIS`) and self-checks it.
- Locks onto start-of-frame.
- Regenerates the expected pattern word by word: frame, line and word index.
- Verifies TLAST/TUSER placement.
- Applies a programmable TREADY backpressure pattern, so the master's handshake logic is exercised under stall.
- Exposes frame and error counters for the testbench and the status register file.

---
 rtl/saxis_chk_pkg.sv | 32 +++
 rtl/saxis_ready_gen.sv | 28 ++
 rtl/saxis_frame_checker.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/saxis_chk_pkg.sv
// Shared definitions for the AXI4-Stream frame checker: FSM states, sticky-flag
// indices, payload field positions and the saturating counter helper.
package saxis_chk_pkg;

    typedef enum logic {
        StHunt  = 1'b0,
        StCheck = 1'b1
    } chk_state_e;

    // Sticky error flag bit positions
    localparam int unsigned ERR_DATA       = 0;
    localparam int unsigned ERR_EARLY_LAST = 1;
    localparam int unsigned ERR_MISS_LAST  = 2;
    localparam int unsigned ERR_TUSER      = 3;

    // Payload layout: [31:28] frame, [27:16] line, [15:0] word index
    localparam int unsigned FRAME_MSB = 31;
    localparam int unsigned FRAME_LSB = 28;
    localparam int unsigned LINE_MSB  = 27;
    localparam int unsigned LINE_LSB  = 16;
    localparam int unsigned WORD_MSB  = 15;
    localparam int unsigned WORD_LSB  = 0;

    // Increment by one when en is set, holding at all-ones
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        if (en && (v != 16'hFFFF)) begin
            return v + 16'd1;
        end
        return v;
    endfunction

endpackage

// File: rtl/saxis_ready_gen.sv
// TREADY generator: a free-running 3-bit slot pointer selects one bit of the
// rotating pattern, gated by enable and registered onto TREADY.
module saxis_ready_gen #(
    parameter logic [7:0] READY_PATTERN = 8'hFF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_enable,
    output logic o_tready
);

    logic [2:0] r_ptr;
    logic       r_tready;

    // Advance the slot pointer every cycle and register the masked ready
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr    <= 3'd0;
            r_tready <= 1'b0;
        end else begin
            r_ptr    <= r_ptr + 3'd1;
            r_tready <= i_enable & READY_PATTERN[r_ptr];
        end
    end

    assign o_tready = r_tready;

endmodule

// File: rtl/saxis_frame_checker.sv
// AXI4-Stream slave that locks onto start-of-frame, regenerates the expected
// frame/line/word payload, checks TLAST/TUSER placement and counts frames and errors.
module saxis_frame_checker
    import saxis_chk_pkg::*;
#(
    parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned PIXELS_HORIZONTAL    = 1280,
    parameter int unsigned PIXELS_VERTICAL      = 1024,
    parameter logic [7:0]  READY_PATTERN        = 8'hFF
) (
    input  logic                                S_AXIS_ACLK,
    input  logic                                S_AXIS_ARESET,
    input  logic                                S_AXIS_TVALID,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic [(C_S_AXIS_TDATA_WIDTH/8)-1:0] S_AXIS_TSTRB,
    input  logic                                S_AXIS_TLAST,
    input  logic                                S_AXIS_TUSER,
    output logic                                S_AXIS_TREADY,
    input  logic                                ENABLE,
    input  logic                                CLR_ERR,
    output logic                                LOCKED,
    output logic                                FRAME_DONE,
    output logic [15:0]                         FRAME_COUNT,
    output logic [15:0]                         DATA_ERR_CNT,
    output logic [15:0]                         LINE_ERR_CNT,
    output logic [3:0]                          ERR_STICKY
);

    localparam int unsigned WORDS     = PIXELS_HORIZONTAL / 4;
    localparam logic [15:0] WORD_LAST = 16'(WORDS - 1);
    localparam logic [11:0] LINE_LAST = 12'(PIXELS_VERTICAL - 1);

    chk_state_e  r_state;
    logic [3:0]  r_exp_frame;
    logic [11:0] r_exp_line;
    logic [15:0] r_exp_word;
    logic [15:0] r_frame_count;
    logic        r_frame_done;
    logic [15:0] r_data_err_cnt;
    logic [15:0] r_line_err_cnt;
    logic [3:0]  r_err_sticky;

    logic        w_tready;
    logic        w_accept;
    logic        w_checking;
    logic [31:0] w_exp_data;
    logic        w_sof;
    logic        w_last_word;
    logic        w_last_line;
    logic        w_first_beat;
    logic        w_data_err;
    logic        w_early_last;
    logic        w_miss_last;
    logic        w_tuser_err;
    logic        w_line_err;
    logic [3:0]  w_new_err;
    logic [15:0] w_data_err_base;
    logic [15:0] w_line_err_base;
    logic [3:0]  w_sticky_base;
    logic        w_unused_tstrb;

    saxis_ready_gen #(
        .READY_PATTERN(READY_PATTERN)
    ) u_ready_gen (
        .i_clk   (S_AXIS_ACLK),
        .i_rst   (S_AXIS_ARESET),
        .i_enable(ENABLE),
        .o_tready(w_tready)
    );

    assign w_unused_tstrb = ^S_AXIS_TSTRB;

    assign w_accept     = S_AXIS_TVALID & w_tready;
    assign w_checking   = w_accept && (r_state == StCheck);
    assign w_exp_data   = {r_exp_frame, r_exp_line, r_exp_word};
    // A start-of-frame beat carries TUSER with line 0, word 0
    assign w_sof        = S_AXIS_TUSER && (S_AXIS_TDATA[LINE_MSB:WORD_LSB] == 28'd0);
    assign w_last_word  = (r_exp_word == WORD_LAST);
    assign w_last_line  = (r_exp_line == LINE_LAST);
    assign w_first_beat = (r_exp_line == 12'd0) && (r_exp_word == 16'd0);

    assign w_data_err   = w_checking && (S_AXIS_TDATA[31:0] != w_exp_data);
    assign w_early_last = w_checking && S_AXIS_TLAST && !w_last_word;
    assign w_miss_last  = w_checking && !S_AXIS_TLAST && w_last_word;
    assign w_tuser_err  = w_checking && S_AXIS_TUSER && !w_first_beat;
    assign w_line_err   = w_early_last | w_miss_last | w_tuser_err;

    // Gather this beat's error events into sticky-flag positions
    always_comb begin
        w_new_err                 = 4'b0000;
        w_new_err[ERR_DATA]       = w_data_err;
        w_new_err[ERR_EARLY_LAST] = w_early_last;
        w_new_err[ERR_MISS_LAST]  = w_miss_last;
        w_new_err[ERR_TUSER]      = w_tuser_err;
    end

    // Clear wins over the old value but the current beat's error still lands on top
    assign w_data_err_base = CLR_ERR ? 16'd0 : r_data_err_cnt;
    assign w_line_err_base = CLR_ERR ? 16'd0 : r_line_err_cnt;
    assign w_sticky_base   = CLR_ERR ? 4'b0000 : r_err_sticky;

    // Lock FSM, expected-position tracking, frame counter and frame-done pulse
    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            r_state       <= StHunt;
            r_exp_frame   <= 4'd0;
            r_exp_line    <= 12'd0;
            r_exp_word    <= 16'd0;
            r_frame_count <= 16'd0;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    StHunt: begin
                        if (w_sof) begin
                            r_state     <= StCheck;
                            r_exp_frame <= S_AXIS_TDATA[FRAME_MSB:FRAME_LSB];
                            r_exp_line  <= 12'd0;
                            r_exp_word  <= 16'd1;
                        end
                    end
                    StCheck: begin
                        if (w_tuser_err && w_sof) begin
                            // Misplaced but well-formed SOF: resynchronise on it
                            r_exp_frame <= S_AXIS_TDATA[FRAME_MSB:FRAME_LSB];
                            r_exp_line  <= 12'd0;
                            r_exp_word  <= 16'd1;
                        end else if (w_line_err) begin
                            r_state <= StHunt;
                        end else if (w_last_word) begin
                            r_exp_word <= 16'd0;
                            if (w_last_line) begin
                                r_exp_line    <= 12'd0;
                                r_exp_frame   <= r_exp_frame + 4'd1;
                                r_frame_count <= sat_inc(r_frame_count, 1'b1);
                                r_frame_done  <= 1'b1;
                            end else begin
                                r_exp_line <= r_exp_line + 12'd1;
                            end
                        end else begin
                            r_exp_word <= r_exp_word + 16'd1;
                        end
                    end
                endcase
            end
        end
    end

    // Error counters and sticky flags with synchronous clear
    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            r_data_err_cnt <= 16'd0;
            r_line_err_cnt <= 16'd0;
            r_err_sticky   <= 4'b0000;
        end else begin
            r_data_err_cnt <= sat_inc(w_data_err_base, w_data_err);
            r_line_err_cnt <= sat_inc(w_line_err_base, w_line_err);
            r_err_sticky   <= w_sticky_base | w_new_err;
        end
    end

    assign S_AXIS_TREADY = w_tready;
    assign LOCKED        = (r_state == StCheck);
    assign FRAME_DONE    = r_frame_done;
    assign FRAME_COUNT   = r_frame_count;
    assign DATA_ERR_CNT  = r_data_err_cnt;
    assign LINE_ERR_CNT  = r_line_err_cnt;
    assign ERR_STICKY    = r_err_sticky;

endmodule
